// File: rtl/arc4_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// arc4_sequencer_pkg
// Shared types and constants for the ARC4 sequencer slice.
//   seq_state_t  : sequencer FSM state, also used as the S-RAM grant select
//   DATA_WIDTH / ADDR_WIDTH / KEY_WIDTH : default datapath widths
//   MSG_LEN      : message length handled by the decrypter
//   CNT_WIDTH    : width of the optional run-cycle counter
//   sat_inc()    : saturating increment used by the cycle counter
// -----------------------------------------------------------------------------
package arc4_sequencer_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 8;
    localparam int KEY_WIDTH  = 24;
    localparam int MSG_LEN    = 32;
    localparam int CNT_WIDTH  = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_INIT = 3'd1,
        RUN_KSA  = 3'd2,
        RUN_DEC  = 3'd3,
        DONE     = 3'd4
    } seq_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        if (value == {CNT_WIDTH{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/arc4_sequencer_if.sv
// -----------------------------------------------------------------------------
// arc4_sequencer_if
// Bundles the sequencer's external handshakes and the S-RAM grant bus.
//   start / key / finish / key_out          : lab top level <-> sequencer
//   {init,ksa,dec}_start / _finish          : engine handshakes
//   {init,ksa,dec}_s_addr / _s_data / _s_wren: per-engine S-RAM requests
//   s_addr / s_data / s_wren                : granted S-RAM port
// Modports:
//   master : the environment (top level plus engines) around the sequencer
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface arc4_sequencer_if
    import arc4_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int KEY_W  = KEY_WIDTH
) ();

    logic              start;
    logic [KEY_W-1:0]  key;
    logic              finish;
    logic [KEY_W-1:0]  key_out;

    logic              init_start;
    logic              init_finish;
    logic              ksa_start;
    logic              ksa_finish;
    logic              dec_start;
    logic              dec_finish;

    logic [ADDR_W-1:0] init_s_addr;
    logic [DATA_W-1:0] init_s_data;
    logic              init_s_wren;
    logic [ADDR_W-1:0] ksa_s_addr;
    logic [DATA_W-1:0] ksa_s_data;
    logic              ksa_s_wren;
    logic [ADDR_W-1:0] dec_s_addr;
    logic [DATA_W-1:0] dec_s_data;
    logic              dec_s_wren;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic              s_wren;

    modport master (
        output start, key,
        output init_finish, ksa_finish, dec_finish,
        output init_s_addr, init_s_data, init_s_wren,
        output ksa_s_addr, ksa_s_data, ksa_s_wren,
        output dec_s_addr, dec_s_data, dec_s_wren,
        input  finish, key_out,
        input  init_start, ksa_start, dec_start,
        input  s_addr, s_data, s_wren
    );

    modport slave (
        input  start, key,
        input  init_finish, ksa_finish, dec_finish,
        input  init_s_addr, init_s_data, init_s_wren,
        input  ksa_s_addr, ksa_s_data, ksa_s_wren,
        input  dec_s_addr, dec_s_data, dec_s_wren,
        output finish, key_out,
        output init_start, ksa_start, dec_start,
        output s_addr, s_data, s_wren
    );

endinterface

// File: rtl/arc4_sequencer_s_mux.sv
// -----------------------------------------------------------------------------
// arc4_sequencer_s_mux
// 3:1 grant mux for the single-port S-RAM. Only the engine whose RUN_* state
// is current reaches the RAM; in IDLE/DONE the port is parked at all zeros so
// no stray write can occur.
// Ports:
//   sel_i                       : current sequencer state (grant select)
//   {init,ksa,dec}_addr/data/wren_i : per-engine requests
//   s_addr_o / s_data_o / s_wren_o  : granted RAM port (combinational)
// -----------------------------------------------------------------------------
module arc4_sequencer_s_mux
    import arc4_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int ADDR_W = ADDR_WIDTH
) (
    input  seq_state_t        sel_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [DATA_W-1:0] init_data_i,
    input  logic              init_wren_i,
    input  logic [ADDR_W-1:0] ksa_addr_i,
    input  logic [DATA_W-1:0] ksa_data_i,
    input  logic              ksa_wren_i,
    input  logic [ADDR_W-1:0] dec_addr_i,
    input  logic [DATA_W-1:0] dec_data_i,
    input  logic              dec_wren_i,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic              s_wren_o
);

    // Select the granted engine's request; park the port when no engine runs.
    always_comb begin
        s_addr_o = {ADDR_W{1'b0}};
        s_data_o = {DATA_W{1'b0}};
        s_wren_o = 1'b0;
        case (sel_i)
            RUN_INIT: begin
                s_addr_o = init_addr_i;
                s_data_o = init_data_i;
                s_wren_o = init_wren_i;
            end
            RUN_KSA: begin
                s_addr_o = ksa_addr_i;
                s_data_o = ksa_data_i;
                s_wren_o = ksa_wren_i;
            end
            RUN_DEC: begin
                s_addr_o = dec_addr_i;
                s_data_o = dec_data_i;
                s_wren_o = dec_wren_i;
            end
            default: begin
                s_addr_o = {ADDR_W{1'b0}};
                s_data_o = {DATA_W{1'b0}};
                s_wren_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/arc4_sequencer.sv
// -----------------------------------------------------------------------------
// arc4_sequencer
// Top-level ARC4 controller: runs init (S[i]=i), ksa and the decrypter in
// that order, captures the key on an accepted start, and grants the single
// S-RAM port to the running engine through arc4_sequencer_s_mux.
// Ports:
//   clk_i   : system clock, all state on posedge
//   rst_ni  : asynchronous active-low reset
//   bus     : arc4_sequencer_if.slave (start/key/finish/key_out, engine
//             start/finish handshakes, per-engine and granted S-RAM bus)
//   cycle_count_o : cycles spent in RUN_* states, only when the macro
//                   ARC4_SEQ_CYCLES_EN is defined
// Each start assertion yields exactly one pass; DONE is left only once start
// has been dropped, so a held start never relaunches.
// -----------------------------------------------------------------------------
module arc4_sequencer
    import arc4_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int KEY_W  = KEY_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    arc4_sequencer_if.slave       bus
`ifdef ARC4_SEQ_CYCLES_EN
    ,
    output logic [CNT_WIDTH-1:0]  cycle_count_o
`endif
);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;
    logic             accept_s;
    logic             init_start_s;
    logic             ksa_start_s;
    logic             dec_start_s;
    logic             finish_s;

    // A start is only honoured while idle; starts during a run are ignored.
    assign accept_s = (state_q == IDLE) && bus.start;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only the active engine's finish can advance the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN_INIT: begin
                if (bus.init_finish) begin
                    state_d = RUN_KSA;
                end else begin
                    state_d = RUN_INIT;
                end
            end
            RUN_KSA: begin
                if (bus.ksa_finish) begin
                    state_d = RUN_DEC;
                end else begin
                    state_d = RUN_KSA;
                end
            end
            RUN_DEC: begin
                if (bus.dec_finish) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN_DEC;
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: each start is a pure function of the state register, so
    // it drops in the cycle after the engine's finish is taken.
    always_comb begin
        init_start_s = 1'b0;
        ksa_start_s  = 1'b0;
        dec_start_s  = 1'b0;
        finish_s     = 1'b0;
        case (state_q)
            RUN_INIT: init_start_s = 1'b1;
            RUN_KSA:  ksa_start_s  = 1'b1;
            RUN_DEC:  dec_start_s  = 1'b1;
            DONE:     finish_s     = 1'b1;
            default: begin
                init_start_s = 1'b0;
                ksa_start_s  = 1'b0;
                dec_start_s  = 1'b0;
                finish_s     = 1'b0;
            end
        endcase
    end

    // Key capture: load on accepted start, hold for the whole run.
    always_comb begin
        if (accept_s) begin
            key_d = bus.key;
        end else begin
            key_d = key_q;
        end
    end

    // Key register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q <= {KEY_W{1'b0}};
        end else begin
            key_q <= key_d;
        end
    end

    assign bus.key_out    = key_q;
    assign bus.init_start = init_start_s;
    assign bus.ksa_start  = ksa_start_s;
    assign bus.dec_start  = dec_start_s;
    assign bus.finish     = finish_s;

    arc4_sequencer_s_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_s_mux (
        .sel_i       (state_q),
        .init_addr_i (bus.init_s_addr),
        .init_data_i (bus.init_s_data),
        .init_wren_i (bus.init_s_wren),
        .ksa_addr_i  (bus.ksa_s_addr),
        .ksa_data_i  (bus.ksa_s_data),
        .ksa_wren_i  (bus.ksa_s_wren),
        .dec_addr_i  (bus.dec_s_addr),
        .dec_data_i  (bus.dec_s_data),
        .dec_wren_i  (bus.dec_s_wren),
        .s_addr_o    (bus.s_addr),
        .s_data_o    (bus.s_data),
        .s_wren_o    (bus.s_wren)
    );

`ifdef ARC4_SEQ_CYCLES_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 running_s;

    assign running_s = (state_q == RUN_INIT) || (state_q == RUN_KSA) ||
                       (state_q == RUN_DEC);

    // Run-cycle counter: clear on accepted start, count RUN_* cycles, else hold.
    always_comb begin
        if (accept_s) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (running_s) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Run-cycle counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count_o = cnt_q;
`endif

endmodule
